// File: rtl/ofs_plat_host_chan_tlp_arb_pkg.sv
// Shared types and helpers for the host channel TLP TX arbiters.
package ofs_plat_host_chan_tlp_arb_pkg;

  // Widest requester vector the helpers handle (NUM_REQ is limited to 2..8).
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } t_rr_pick;

  // First valid requester at or after ptr, wrapping at n-1 -> 0.
  function automatic t_rr_pick rr_select(input logic [MAX_REQ-1:0]   valid,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int                   n);
    t_rr_pick             r;
    int                   j;
    logic [MAX_IDX_W-1:0] jj;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j  = (int'(ptr) + k) % n;
      jj = MAX_IDX_W'(j);
      if ((k < n) && !r.found && valid[jj]) begin
        r.found = 1'b1;
        r.idx   = jj;
      end
    end
    return r;
  endfunction

  // Round-robin pointer advance past idx, modulo n.
  function automatic logic [MAX_IDX_W-1:0] rr_next(input logic [MAX_IDX_W-1:0] idx,
                                                    input int                   n);
    return MAX_IDX_W'((int'(idx) + 1) % n);
  endfunction

endpackage

// File: rtl/ofs_plat_prim_rr_pick.sv
// Combinational rotating-priority picker: one-hot and index of the first
// valid requester at or after the pointer.
module ofs_plat_prim_rr_pick
  import ofs_plat_host_chan_tlp_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  logic [MAX_REQ-1:0] w_valid;
  t_rr_pick           w_pick;

  // Widen the request vector and run the shared rotating search.
  always_comb begin
    w_valid                = '0;
    w_valid[NUM_REQ-1:0]   = i_valid;
    w_pick                 = rr_select(w_valid, MAX_IDX_W'(i_ptr), NUM_REQ);
    o_found                = w_pick.found;
    o_idx                  = IDX_W'(w_pick.idx);
    o_onehot               = '0;
    if (w_pick.found) o_onehot = NUM_REQ'(1) << w_pick.idx;
  end

endmodule

// File: rtl/ofs_plat_host_chan_tlp_tx_arb.sv
// Packet-atomic round-robin merge of several TLP TX streams onto one
// registered host channel AXI-S output.
module ofs_plat_host_chan_tlp_tx_arb
  import ofs_plat_host_chan_tlp_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 512,
  parameter  int USER_WIDTH = 10,
  parameter  int PRIO_PORT0 = 0,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            in_tvalid,
  output logic [NUM_REQ-1:0]            in_tready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_REQ*USER_WIDTH-1:0] in_tuser,
  input  logic [NUM_REQ-1:0]            in_tlast,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic [DATA_WIDTH-1:0]         out_tdata,
  output logic [USER_WIDTH-1:0]         out_tuser,
  output logic                          out_tlast,
  input  logic                          pause,
  output logic                          busy,
  output logic [IDX_W-1:0]              cur_owner
);

  t_arb_state            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_owner, w_owner_nxt;
  logic [IDX_W-1:0]      r_rr_ptr, w_rr_nxt;
  logic                  r_out_tvalid, r_out_tlast;
  logic [DATA_WIDTH-1:0] r_out_tdata;
  logic [USER_WIDTH-1:0] r_out_tuser;

  logic [NUM_REQ-1:0]    w_pick_1h;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_found;
  logic [IDX_W-1:0]      w_sel;
  logic [NUM_REQ-1:0]    w_sel_1h;
  logic                  w_sel_ok;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [USER_WIDTH-1:0] w_sel_user;
  logic                  w_load_en;
  logic                  w_acc;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return IDX_W'(rr_next(MAX_IDX_W'(p), NUM_REQ));
  endfunction

  ofs_plat_prim_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_valid  (in_tvalid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_1h),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  // Choose the requester for this cycle: locked owner, priority port, or round-robin.
  always_comb begin
    w_sel    = '0;
    w_sel_1h = '0;
    w_sel_ok = 1'b0;
    if (r_state == LOCKED) begin
      w_sel    = r_owner;
      w_sel_1h = NUM_REQ'(1) << r_owner;
      w_sel_ok = in_tvalid[r_owner];
    end else if (!pause) begin
      if ((PRIO_PORT0 != 0) && in_tvalid[0]) begin
        w_sel_1h = NUM_REQ'(1);
        w_sel_ok = 1'b1;
      end else begin
        w_sel    = w_pick_idx;
        w_sel_1h = w_pick_1h;
        w_sel_ok = w_pick_found;
      end
    end
  end

  // Route the selected requester's beat toward the output register.
  always_comb begin
    w_sel_data = '0;
    w_sel_user = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_sel_data = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_user = in_tuser[i*USER_WIDTH +: USER_WIDTH];
        w_sel_last = in_tlast[i];
      end
    end
  end

  // The output register takes a new beat when empty or draining; reset blocks all handshakes.
  assign w_load_en = !r_out_tvalid | out_tready;
  assign w_acc     = w_load_en & w_sel_ok & reset_n;
  assign in_tready = w_acc ? w_sel_1h : '0;

  // Next-state: lock on a multi-beat SOP, release and advance the pointer on EOP.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_owner_nxt = w_sel;
          if (w_sel_last) w_rr_nxt    = ptr_inc(w_sel);
          else            w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_acc && w_sel_last) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = ptr_inc(r_owner);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Arbitration state, owner and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Registered output beat; holds steady under downstream backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_tvalid <= 1'b0;
      r_out_tlast  <= 1'b0;
      r_out_tdata  <= '0;
      r_out_tuser  <= '0;
    end else if (w_load_en) begin
      r_out_tvalid <= w_sel_ok;
      r_out_tlast  <= w_sel_ok & w_sel_last;
      if (w_sel_ok) begin
        r_out_tdata <= w_sel_data;
        r_out_tuser <= w_sel_user;
      end
    end
  end

  assign out_tvalid = r_out_tvalid;
  assign out_tlast  = r_out_tlast;
  assign out_tdata  = r_out_tdata;
  assign out_tuser  = r_out_tuser;
  assign busy       = (r_state == LOCKED) | r_out_tvalid;
  assign cur_owner  = r_owner;

endmodule

// File: tb/tb_ofs_plat_host_chan_tlp_tx_arb.sv
// Directed bench for the TLP TX arbiter (round-robin and port-0 priority builds).
module tb_ofs_plat_host_chan_tlp_tx_arb;
  import ofs_plat_host_chan_tlp_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int UW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  in_tvalid = '0;
  logic [N-1:0]  in_tlast = '0;
  logic [N*DW-1:0] in_tdata = '0;
  logic [N*UW-1:0] in_tuser = '0;
  logic          out_tready = 1'b1;
  logic          pause = 1'b0;

  logic [N-1:0]  in_tready, rdy_p;
  logic          out_tvalid, out_tlast, ov_p, ol_p, busy, busy_p;
  logic [DW-1:0] out_tdata, od_p;
  logic [UW-1:0] out_tuser, ou_p;
  logic [1:0]    cur_owner, own_p;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] en;
  int len [N];
  int bcnt [N];
  logic use_p = 1'b0;

  always #5 clk = ~clk;

  ofs_plat_host_chan_tlp_tx_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .PRIO_PORT0(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tuser(out_tuser), .out_tlast(out_tlast), .pause(pause), .busy(busy),
    .cur_owner(cur_owner));

  ofs_plat_host_chan_tlp_tx_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .PRIO_PORT0(1)) dut_p (
    .clk(clk), .reset_n(reset_n), .in_tvalid(in_tvalid), .in_tready(rdy_p),
    .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .out_tvalid(ov_p), .out_tready(out_tready), .out_tdata(od_p),
    .out_tuser(ou_p), .out_tlast(ol_p), .pause(pause), .busy(busy_p),
    .cur_owner(own_p));

  function automatic logic [31:0] dval(input int p, input int b);
    return 32'hD000_0000 | (32'(p) << 8) | 32'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive requester beats, check readiness, advance accepted beats.
  task automatic cyc(input logic [N-1:0] exp_rdy, input string tag);
    logic [N-1:0] rdy;
    logic [N-1:0] lst;
    for (int p = 0; p < N; p++) begin
      lst[p]                 = (bcnt[p] == len[p] - 1);
      in_tvalid[p]           = en[p];
      in_tlast[p]            = lst[p];
      in_tdata[p*DW +: DW]   = dval(p, bcnt[p]);
      in_tuser[p*UW +: UW]   = {4'(p), 6'(bcnt[p])};
    end
    #1;
    rdy = use_p ? rdy_p : in_tready;
    chk(tag, 32'(rdy), 32'(exp_rdy));
    @(posedge clk); #1;
    for (int p = 0; p < N; p++)
      if (rdy[p]) bcnt[p] = lst[p] ? 0 : bcnt[p] + 1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    en         = '0;
    in_tvalid  = '0;
    pause      = 1'b0;
    out_tready = 1'b1;
    for (int p = 0; p < N; p++) begin
      bcnt[p] = 0;
      len[p]  = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state, with requesters already offering beats.
    do_reset();
    reset_n = 1'b0;
    in_tvalid = 4'hF;
    #1;
    chk("rst_tready", 32'(in_tready), 32'h0);
    chk("rst_tready_p", 32'(rdy_p), 32'h0);
    chk("rst_tvalid", 32'(out_tvalid), 32'h0);
    chk("rst_tdata", out_tdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(cur_owner), 32'h0);

    // Single-beat packets alternating between req0 and req3.
    do_reset();
    en = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (k % 2 == 0) ? 0 : 3;
      cyc(4'(1 << p), "sb_rdy");
      chk("sb_valid", 32'(out_tvalid), 32'h1);
      chk("sb_data", out_tdata, dval(p, 0));
      chk("sb_owner", 32'(cur_owner), 32'(p));
      chk("sb_rrptr", 32'(dut.r_rr_ptr), (p == 0) ? 32'h1 : 32'h0);
    end
    chk("sb_user", 32'(out_tuser), 32'h0C0);

    // Round-robin fairness with 2-beat packets from everyone.
    do_reset();
    en = 4'hF;
    for (int p = 0; p < N; p++) len[p] = 2;
    for (int k = 0; k < 8; k++) begin
      cyc(4'(1 << (k / 2)), "rr_rdy");
      chk("rr_valid", 32'(out_tvalid), 32'h1);
      chk("rr_data", out_tdata, dval(k / 2, k % 2));
      chk("rr_last", 32'(out_tlast), 32'(k % 2));
    end

    // Reset in the middle of a 4-beat packet from req1.
    do_reset();
    len[1] = 4;
    en = 4'b0010;
    cyc(4'b0010, "mr_b0");
    cyc(4'b0010, "mr_b1");
    reset_n = 1'b0;
    #1;
    chk("mr_tvalid", 32'(out_tvalid), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_tready", 32'(in_tready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int p = 0; p < N; p++) bcnt[p] = 0;
    en = 4'b0100;
    len[2] = 2;
    chk("mr_state", 32'(dut.r_state), 32'(IDLE));
    chk("mr_rrptr", 32'(dut.r_rr_ptr), 32'h0);
    cyc(4'b0100, "mr_req2");
    chk("mr_data", out_tdata, dval(2, 0));

    // Lock held across valid gaps and output backpressure.
    do_reset();
    len[2] = 3;
    len[0] = 2;
    en = 4'b0100; out_tready = 1'b1;
    cyc(4'b0100, "lk_c0");
    chk("lk_c0_data", out_tdata, dval(2, 0));
    en = 4'b0001; out_tready = 1'b0;
    cyc(4'b0000, "lk_c1");
    chk("lk_c1_valid", 32'(out_tvalid), 32'h1);
    chk("lk_c1_hold", out_tdata, dval(2, 0));
    out_tready = 1'b1;
    cyc(4'b0000, "lk_c2");
    chk("lk_c2_valid", 32'(out_tvalid), 32'h0);
    chk("lk_c2_busy", 32'(busy), 32'h1);
    en = 4'b0101; out_tready = 1'b0;
    cyc(4'b0100, "lk_c3");
    chk("lk_c3_data", out_tdata, dval(2, 1));
    out_tready = 1'b1;
    cyc(4'b0100, "lk_c4");
    chk("lk_c4_data", out_tdata, dval(2, 2));
    chk("lk_c4_last", 32'(out_tlast), 32'h1);
    en = 4'b0001; out_tready = 1'b0;
    cyc(4'b0000, "lk_c5");
    chk("lk_c5_hold", out_tdata, dval(2, 2));
    chk("lk_c5_valid", 32'(out_tvalid), 32'h1);
    out_tready = 1'b1;
    cyc(4'b0001, "lk_c6");
    chk("lk_c6_data", out_tdata, dval(0, 0));

    // Pause during req1's second beat; req2 waits for pause to drop.
    do_reset();
    len[1] = 4;
    len[2] = 2;
    en = 4'b0110;
    cyc(4'b0010, "pz_b0");
    pause = 1'b1;
    cyc(4'b0010, "pz_b1");
    cyc(4'b0010, "pz_b2");
    cyc(4'b0010, "pz_b3");
    chk("pz_b3_data", out_tdata, dval(1, 3));
    chk("pz_b3_busy", 32'(busy), 32'h1);
    cyc(4'b0000, "pz_idle0");
    chk("pz_idle0_valid", 32'(out_tvalid), 32'h0);
    chk("pz_idle0_busy", 32'(busy), 32'h0);
    cyc(4'b0000, "pz_idle1");
    chk("pz_idle1_busy", 32'(busy), 32'h0);
    pause = 1'b0;
    cyc(4'b0100, "pz_req2");
    chk("pz_req2_data", out_tdata, dval(2, 0));
    chk("pz_req2_busy", 32'(busy), 32'h1);

    // Port-0 priority build: req0 wins over req1 once req3's packet ends.
    use_p = 1'b1;
    do_reset();
    len[3] = 3;
    len[0] = 1;
    len[1] = 2;
    en = 4'b1000;
    cyc(4'b1000, "pr_b0");
    en = 4'b1011;
    cyc(4'b1000, "pr_b1");
    cyc(4'b1000, "pr_b2");
    cyc(4'b0001, "pr_req0a");
    chk("pr_req0a_data", od_p, dval(0, 0));
    cyc(4'b0001, "pr_req0b");
    en = 4'b1010;
    cyc(4'b0010, "pr_req1");
    chk("pr_req1_data", od_p, dval(1, 0));
    chk("pr_req1_owner", 32'(own_p), 32'h1);
    use_p = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofs_plat_host_chan_tlp_tx_arb.md
Name: ofs_plat_host_chan_tlp_tx_arb

Overview:
- Packet-atomic round-robin arbiter that merges several AFU-side PCIe TLP TX streams onto the single host channel TX AXI-S port of ofs_plat_host_chan_axis_pcie_tlp_if.
- Requesters are typically the MMIO read-completion path, DMA read/write request generators and the interrupt generator.
- A grant is held from SOP to tlast, so TLPs are never interleaved.
- The output is registered; a pause input allows software reset and flush logic to drain the channel cleanly.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8).
- DATA_WIDTH, 512, tdata width per beat.
- USER_WIDTH, 10, tuser width per beat (header/SOP flags, carried opaque).
- PRIO_PORT0, 0, 1 = port 0 (MMIO completions) has strict priority at packet boundaries; 0 = pure round-robin.

Ports:
- clk  in  1  host channel clock (pClk).
- reset_n  in  1  asynchronous active-low reset.
- in_tvalid  in  NUM_REQ  per-requester beat valid.
- in_tready  out  NUM_REQ  per-requester beat accept.
- in_tdata  in  NUM_REQ*DATA_WIDTH  packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_tuser  in  NUM_REQ*USER_WIDTH  packed user bits.
- in_tlast  in  NUM_REQ  end-of-packet.
- out_tvalid  out  1  merged beat valid (registered).
- out_tready  in  1  downstream accept.
- out_tdata  out  DATA_WIDTH  merged beat.
- out_tuser  out  USER_WIDTH  merged user.
- out_tlast  out  1  merged end-of-packet.
- pause  in  1  block new packet starts; in-flight packet completes.
- busy  out  1  1 while a packet is locked or out_tvalid=1.
- cur_owner  out  $clog2(NUM_REQ)  owner of the locked/last granted packet.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out_tvalid=0, out_tlast=0; out_tdata/out_tuser=0.
  - state=IDLE, rr_ptr=0, cur_owner=0, busy=0, all in_tready=0.
- Pipeline: out register loads when load_en = !out_tvalid | out_tready.
  - out_tvalid' = load_en ? (selected beat valid) : out_tvalid.
  - Latency from input handshake to out_tvalid is 1 cycle.
  - Full throughput: 1 beat/cycle when out_tready is held high.
- in_tready[i] = load_en & (i == selected) & selection legal. It depends combinationally on out_tready. No in_tready is asserted while reset_n=0.
- State machine:
  - IDLE:
    - If pause=1, no selection is made.
    - Otherwise, if PRIO_PORT0=1 and in_tvalid[0]=1, port 0 is selected.
    - Otherwise the first valid requester searching from rr_ptr upward, with wrap at NUM_REQ-1 -> 0, is selected.
    - On an accepted beat with in_tlast=0: go to LOCKED(owner=sel).
    - On an accepted beat with in_tlast=1 (single-beat TLP): stay in IDLE and set rr_ptr=sel+1 (mod NUM_REQ).
    - cur_owner=sel on any accepted SOP.
  - LOCKED(owner):
    - Only owner may be selected; pause is ignored.
    - A gap in the owner's in_tvalid holds the lock. Other requesters stay at in_tready=0.
    - On an accepted beat with in_tlast=1: go to IDLE and set rr_ptr=owner+1 (mod NUM_REQ).
- Simultaneous events:
  - An EOP acceptance and a new SOP cannot occur in the same cycle on one output beat.
  - The next packet may start in the cycle after the EOP is accepted.
  - Arbitration in IDLE uses the rr_ptr value current in that cycle.
- pause asserted mid-packet: the packet completes. Deasserting pause re-enables starts in the same cycle.
- busy = (state==LOCKED) | out_tvalid. Flush logic waits for pause=1 & busy=0.
- Backpressure: while out_tvalid=1 and out_tready=0, the out register is stable and all in_tready=0.
- A requester dropping in_tvalid before handshake is legal upstream misbehaviour. The arbiter re-evaluates each IDLE cycle and does not record a grant.

Decomposition:
- Shared package ofs_plat_host_chan_tlp_arb_pkg:
  - t_arb_state enum (IDLE, LOCKED).
  - function rr_select(valid vector, ptr) returning the index and a found flag.
- One sub-module, ofs_plat_prim_rr_pick: combinational rotating-priority picker (NUM_REQ valids, ptr in -> one-hot + index out), reused by other host channel arbiters.
- The top module holds the FSM, pointer and output register.

Test Plan:
- Reset mid-packet:
  - Stimulus: req1 sends a 4-beat TLP; reset_n drops after beat 2, then rises.
  - Required: out_tvalid=0 immediately; state IDLE and rr_ptr=0 after release; req2's next packet is granted without waiting for req1's tlast.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously offer 2-beat TLPs with out_tready=1.
  - Required: output owner sequence 0,1,2,3,0... with 8 beats per 8 cycles and no interleave.
- Lock across gaps and backpressure:
  - Stimulus: req2 sends 3 beats with a 2-cycle valid gap after beat 1, while req0 is valid throughout; out_tready toggles 1,0,1,0.
  - Required: req0 sees in_tready=0 until req2's tlast is accepted; out beats are stable while out_tready=0.
- Strict priority:
  - Stimulus: PRIO_PORT0=1; req1 and req0 valid simultaneously in IDLE while req3 is locked.
  - Required: after req3's EOP, req0 is granted before req1.
- Pause:
  - Stimulus: pause=1 during req1's beat 2 of 4.
  - Required: all 4 beats go out; busy falls 1 cycle after the last beat is accepted downstream; no new SOP while pause=1; req2 is granted the cycle pause=0.
- Single-beat packets:
  - Stimulus: req0 and req3 alternate 1-beat TLPs.
  - Required: back-to-back output (one beat per cycle), rr_ptr alternates 1 and 0, cur_owner tracks 0 and 3.
